// File: rtl/l2_arbiter.sv
// Arbitrates instruction and data L1 miss traffic onto one shared L2 port.
// Optional `ARB_ROUND_ROBIN_EN: ties alternate I/D; otherwise D always wins ties.
module l2_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic         i_resp,
    output logic [255:0] i_rdata,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic         d_resp,
    output logic [255:0] d_rdata,
    output logic         l2_read,
    output logic         l2_write,
    output logic [31:0]  l2_address,
    output logic [255:0] l2_wdata,
    input  logic         l2_resp,
    input  logic [255:0] l2_rdata
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

    state_e         state;
    logic [31:0]    addr_q;
    logic [255:0]   wdata_q;
    logic           write_q;
    logic           i_req;
    logic           d_req;
    logic           grant_i;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign grant_i = i_req && (!d_req || last_d);
`else
    assign grant_i = i_req && !d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  <= 1'b1;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_req || d_req) begin
                        if (grant_i) begin
                            state   <= StServeI;
                            addr_q  <= i_address;
                            wdata_q <= '0;
                            write_q <= 1'b0;
                        end else begin
                            // d_write dominates when both d_read and d_write are high
                            state   <= StServeD;
                            addr_q  <= d_address;
                            wdata_q <= d_wdata;
                            write_q <= d_write;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_d <= !grant_i;
`endif
                    end
                end
                StServeI, StServeD: begin
                    if (l2_resp) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // L2 port is a pure decode of latched state, so it cannot follow requester inputs
    assign l2_read    = (state != StIdle) && !write_q;
    assign l2_write   = (state != StIdle) && write_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;

    assign i_resp  = (state == StServeI) && l2_resp;
    assign d_resp  = (state == StServeD) && l2_resp;
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized and directed bench for l2_arbiter against a transaction-level model.
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic         i_resp;
    logic [255:0] i_rdata;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic         d_resp;
    logic [255:0] d_rdata;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic         l2_resp = 1'b0;
    logic [255:0] l2_rdata = '0;

    int errors = 0;
    int checks = 0;

    l2_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_resp(l2_resp), .l2_rdata(l2_rdata)
    );

    always #5 clk = ~clk;

    // Model: one outstanding transaction description plus who won last
    bit          m_busy;
    bit          m_for_i;
    bit          m_write;
    bit [31:0]   m_addr;
    bit [255:0]  m_wdata;
    bit          m_last_was_d;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_for_i = 0; m_write = 0; m_addr = '0; m_wdata = '0;
        m_last_was_d = 1;
    endtask

    task automatic model_step();
        bit want_i, want_d, to_i, tie_to_i;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (l2_resp) m_busy = 0;
        end else begin
            want_i = i_read;
            want_d = d_read || d_write;
`ifdef ARB_ROUND_ROBIN_EN
            tie_to_i = m_last_was_d;
`else
            tie_to_i = 0;
`endif
            if (want_i || want_d) begin
                to_i = want_i && (!want_d || tie_to_i);
                m_busy = 1;
                m_for_i = to_i;
                m_addr = to_i ? i_address : d_address;
                m_wdata = to_i ? '0 : d_wdata;
                m_write = !to_i && d_write;
                m_last_was_d = !to_i;
            end
        end
    endtask

    // Called shortly after a negedge once inputs are driven
    task automatic eval();
        #1;
        chk("l2_read", l2_read, m_busy && !m_write);
        chk("l2_write", l2_write, m_busy && m_write);
        chk("l2_address", l2_address, m_addr);
        chk("l2_wdata", l2_wdata, m_wdata);
        chk("i_resp", i_resp, m_busy && m_for_i && l2_resp);
        chk("d_resp", d_resp, m_busy && !m_for_i && l2_resp);
        chk("i_rdata", i_rdata, l2_rdata);
        chk("d_rdata", d_rdata, l2_rdata);
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    endtask

    // Async pulse mid-cycle; outputs must drop before any clock edge
    task automatic do_reset();
        #3;
        rst = 1;
        #1;
        chk("rst l2_read", l2_read, 0);
        chk("rst l2_write", l2_write, 0);
        chk("rst i_resp", i_resp, 0);
        chk("rst d_resp", d_resp, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic [255:0] pat_a5;
        logic [255:0] pat_wb;
        logic [3:0]   order;
        int           nresp;

        pat_a5 = {32{8'hA5}};
        pat_wb = {8{32'h1234_5678}};
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset l2_address", l2_address, 0);
        chk("reset l2_read", l2_read, 0);
        rst = 0;

        // Lone instruction read
        i_read = 1; i_address = 32'h0000_0040;
        eval(); chk("lone idle l2_read", l2_read, 0);
        adv();
        eval(); chk("lone l2_read", l2_read, 1); chk("lone l2_address", l2_address, 32'h40);
        adv(); eval(); adv(); eval(); adv();
        l2_resp = 1; l2_rdata = pat_a5;
        eval();
        chk("lone i_resp", i_resp, 1); chk("lone i_rdata", i_rdata, pat_a5);
        chk("lone d_resp", d_resp, 0);
        adv();
        idle_inputs();
        eval(); chk("lone i_resp drop", i_resp, 0); chk("lone l2_read drop", l2_read, 0);
        adv();

        // Write-back
        d_write = 1; d_address = 32'h8000_0020; d_wdata = pat_wb;
        eval(); adv();
        for (int k = 0; k < 2; k++) begin
            eval();
            chk("wb l2_write", l2_write, 1); chk("wb l2_read", l2_read, 0);
            chk("wb addr", l2_address, 32'h8000_0020); chk("wb data", l2_wdata, pat_wb);
            adv();
        end
        l2_resp = 1;
        eval(); chk("wb d_resp", d_resp, 1); chk("wb i_resp", i_resp, 0);
        adv();
        idle_inputs();
        eval(); chk("wb d_resp drop", d_resp, 0); chk("wb l2_write drop", l2_write, 0);
        adv();

        // Requester drops right after grant
        i_read = 1; i_address = 32'h0000_0100;
        eval(); adv();
        i_read = 0; i_address = 32'hDEAD_BEEC;
        eval(); chk("drop l2_read", l2_read, 1); chk("drop addr", l2_address, 32'h100);
        adv();
        l2_resp = 1;
        eval(); chk("drop i_resp", i_resp, 1);
        adv();
        l2_resp = 0;
        eval(); chk("drop i_resp once", i_resp, 0);
        adv();

        // Spurious l2_resp in IDLE
        l2_resp = 1;
        eval(); chk("spur i_resp", i_resp, 0); chk("spur d_resp", d_resp, 0);
        adv();
        l2_resp = 0;
        eval(); chk("spur idle", {l2_read, l2_write}, 2'b00);
        adv();

        // Reset during SERVE_D
        d_write = 1; d_read = 0; d_address = 32'h0000_0080; d_wdata = pat_a5;
        eval(); adv();
        eval(); chk("rstd l2_write", l2_write, 1);
        l2_resp = 1;
        do_reset();
        chk("rstd no d_resp", d_resp, 0);
        idle_inputs();
        i_read = 1; i_address = 32'h0000_0200;
        eval(); adv();
        eval(); chk("after rst l2_read", l2_read, 1); chk("after rst addr", l2_address, 32'h200);
        l2_resp = 1;
        adv();
        idle_inputs();
        eval(); adv();

        // Held tie right after reset
        do_reset();
        i_read = 1; d_read = 1; d_write = 0; i_address = 32'h10; d_address = 32'h20;
        l2_resp = 1;
        order = '0; nresp = 0;
        for (int k = 0; k < 8; k++) begin
            eval();
            if (i_resp || d_resp) begin
                if (nresp < 4) order[3 - nresp] = i_resp;
                nresp++;
            end
            adv();
        end
        chk("tie count", nresp, 4);
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie order", order, 4'b1010);
`else
        chk("tie order", order, 4'b0000);
`endif
        idle_inputs();
        eval(); adv();

        // Randomized traffic with occasional async reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            i_read = ($urandom_range(0, 2) == 0);
            d_read = ($urandom_range(0, 2) == 0);
            d_write = ($urandom_range(0, 3) == 0);
            i_address = $urandom();
            d_address = $urandom();
            d_wdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
            l2_resp = ($urandom_range(0, 2) == 0);
            l2_rdata = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
            eval();
            chk("exclusive", l2_read && l2_write, 0);
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 The block SHALL have no parameters; line width is fixed at 256 bits and address width at 32 bits.
REQ-002 clk  input  1  the single clock for the block; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 i_read  input  1  instruction L1 miss read request; i_address  input  32  its line address.
REQ-005 i_resp  output  1  one-cycle completion to the instruction L1; i_rdata  output  256  the returned line.
REQ-006 d_read / d_write  input  1 each  data L1 read request / write-back request.
REQ-007 d_address  input  32  data L1 line address; d_wdata  input  256  write-back line.
REQ-008 d_resp  output  1  one-cycle completion to the data L1; d_rdata  output  256  the returned line.
REQ-009 l2_read / l2_write  output  1 each  request to the shared L2 port.
REQ-010 l2_address  output  32  L2 line address; l2_wdata  output  256  L2 write line.
REQ-011 l2_resp  input  1  L2 completion; l2_rdata  input  256  L2 read line.

Function
REQ-012 The FSM SHALL have three states: IDLE, SERVE_I, SERVE_D.
REQ-013 In IDLE with only i_read high, the next state SHALL be SERVE_I.
REQ-014 In IDLE with only d_read or d_write high, the next state SHALL be SERVE_D.
REQ-015 In IDLE with both requesters active, the tie SHALL resolve per REQ-027/REQ-028.
REQ-016 On leaving IDLE, the block SHALL latch the winner's address, wdata and direction into internal registers.
REQ-017 l2_read, l2_write, l2_address and l2_wdata SHALL be driven only from the latched registers.
- Latency: a request sampled in IDLE at edge N reaches the L2 port in the cycle after N.
REQ-018 The block SHALL hold l2_read or l2_write high, with stable address and data, until l2_resp.
- This holds even if the requester deasserts its request mid-transaction.
REQ-019 If d_read and d_write are both high, the block SHALL treat the request as a write.
REQ-020 On l2_resp in SERVE_x:
- x_resp SHALL be asserted combinationally in the same cycle.
- x_rdata SHALL equal l2_rdata in that cycle.
- The FSM SHALL return to IDLE at the next edge.
REQ-021 The non-served requester's resp SHALL stay low.
- Both i_rdata and d_rdata SHALL pass l2_rdata unconditionally; resp qualifies them.
REQ-022 l2_resp arriving in IDLE SHALL be ignored; no resp is produced.
REQ-023 A requester still asserting in the IDLE cycle after its resp SHALL start a new transaction.
- Requesters deassert the cycle after resp.
REQ-024 l2_read and l2_write SHALL never be high simultaneously, and never high in IDLE.

Reset
REQ-025 Asserting rst SHALL immediately force:
- state = IDLE;
- l2_read = l2_write = i_resp = d_resp = 0;
- latched address/data = 0;
- last-grant register = D.
REQ-026 Reset mid-transaction SHALL abandon the L2 access without producing a resp.
- The first edge after deassertion samples requests in IDLE.

Configuration
REQ-027 With ARB_ROUND_ROBIN_EN defined:
- A tie SHALL be granted to the requester not granted last.
- The last-grant register SHALL update on every grant.
- The first tie after reset goes to I.
REQ-028 Without ARB_ROUND_ROBIN_EN:
- A tie SHALL always grant D (fixed data priority).
- The last-grant register SHALL be absent.

Verification
REQ-029 Lone read, i_read=1, i_address=0x0000_0040, L2 responds 3 cycles later with rdata=0xA5..A5:
- l2_read rises one cycle after the request and falls after resp.
- i_resp pulses 1 cycle with i_rdata=0xA5..A5.
- d_resp stays 0.
REQ-030 Write-back, d_write=1, d_address=0x8000_0020, d_wdata=0x1234..:
- l2_write=1 with identical address and data until l2_resp.
- d_resp pulses 1 cycle.
REQ-031 Simultaneous i_read and d_read after reset, with ARB_ROUND_ROBIN_EN:
- I is served first, then D.
- Both held and repeated: grants alternate I,D,I,D.
- Without the macro: D,D,D while D is held.
REQ-032 Reset during SERVE_D, with l2_write high and rst pulsed:
- l2_write drops asynchronously.
- No d_resp.
- The next request is served from IDLE.
REQ-033 Requester drop, i_read deasserted one cycle after grant:
- l2_read and l2_address are held unchanged until l2_resp.
- i_resp still pulses once.
REQ-034 Spurious l2_resp in IDLE:
- No i_resp/d_resp.
- State stays IDLE.
